// File: rtl/game_pkg.sv
// Shared game constants and FSM state encoding for judge, renderer and pipe generator.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package game_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_PLAY = 2'b01,
        ST_OVER = 2'b10
    } state_e;

    // Screen geometry in pixels
    localparam int unsigned BIRD_X   = 200;
    localparam int unsigned BIRD_W   = 34;
    localparam int unsigned BIRD_H   = 24;
    localparam int unsigned PIPE_W   = 52;
    localparam int unsigned GAP_H    = 120;
    localparam int unsigned GROUND_Y = 400;

    // Coordinates are widened to 13 bits before any sum so nothing wraps at 4095
    function automatic logic [12:0] ext13(input logic [11:0] v);
        return {1'b0, v};
    endfunction

endpackage

// File: rtl/bcd_counter4.sv
// Four-digit BCD up-counter with synchronous clear, saturating at 9999.
// Latency: new value visible one clk after inc/clr.
// Backpressure: none; inc is accepted every cycle, ignored once saturated.
module bcd_counter4 (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        inc,
    output logic [15:0] val
);

    logic [15:0] val_q, val_d;
    logic        carry;

    // Next value: clear wins, otherwise ripple a +1 through the digits
    always_comb begin
        val_d = val_q;
        carry = 1'b1;
        if (clr) begin
            val_d = 16'h0000;
        end else if (inc && (val_q != 16'h9999)) begin
            for (int i = 0; i < 4; i++) begin
                if (carry) begin
                    if (val_q[i*4 +: 4] == 4'd9) begin
                        val_d[i*4 +: 4] = 4'd0;
                    end else begin
                        val_d[i*4 +: 4] = val_q[i*4 +: 4] + 4'd1;
                        carry           = 1'b0;
                    end
                end
            end
        end
    end

    // Counter register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) val_q <= 16'h0000;
        else     val_q <= val_d;
    end

    assign val = val_q;

endmodule

// File: rtl/pipe_judge.sv
// Game FSM: pipe/ground collision, pass scoring into BCD score and best score.
// Latency: state change one clk after the deciding en; score +1 one clk after the pass edge.
// Backpressure: none; up to three passes per tick are queued in pending and drained one per clk.
module pipe_judge
    import game_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        start,
    input  logic [11:0] bird_y,
    input  logic [11:0] pipe1_x,
    input  logic [11:0] pipe2_x,
    input  logic [11:0] pipe3_x,
    input  logic [11:0] pipe1_y,
    input  logic [11:0] pipe2_y,
    input  logic [11:0] pipe3_y,
    output logic [1:0]  state,
    output logic        game_over,
    output logic        score_pulse,
    output logic [15:0] score_bcd,
    output logic [15:0] best_bcd
);

    state_e      state_q, state_d;
    logic [2:0]  passed_q, passed_d;
    logic [1:0]  pending_q, pending_d;
    logic        score_pulse_q, score_pulse_d;
    logic [15:0] best_q, best_d;

    logic [11:0] px [3];
    logic [11:0] py [3];
    logic [12:0] bird_bot;
    logic [12:0] px_right;
    logic [2:0]  hit_pipe, pass_set, pass_clr;
    logic        hit, eval, drain;
    logic [1:0]  n_new;
    logic [2:0]  pend_sum;

    assign px[0] = pipe1_x;
    assign px[1] = pipe2_x;
    assign px[2] = pipe3_x;
    assign py[0] = pipe1_y;
    assign py[1] = pipe2_y;
    assign py[2] = pipe3_y;

    // Collision and pass geometry; touching a gap edge exactly is safe
    always_comb begin
        bird_bot = ext13(bird_y) + 13'(BIRD_H);
        hit_pipe = 3'b000;
        pass_set = 3'b000;
        pass_clr = 3'b000;
        px_right = 13'd0;
        for (int i = 0; i < 3; i++) begin
            px_right    = ext13(px[i]) + 13'(PIPE_W);
            hit_pipe[i] = (ext13(px[i]) < 13'(BIRD_X + BIRD_W)) && (px_right > 13'(BIRD_X)) &&
                          ((ext13(bird_y) < ext13(py[i])) ||
                           (bird_bot > ext13(py[i]) + 13'(GAP_H)));
            pass_set[i] = (px_right < 13'(BIRD_X)) && !passed_q[i];
            pass_clr[i] = ext13(px[i]) >= 13'(BIRD_X);
        end
        hit = (bird_bot >= 13'(GROUND_Y)) || (|hit_pipe);
    end

    // FSM next state, pass flags, pending queue and best score
    always_comb begin
        state_d       = state_q;
        passed_d      = passed_q;
        pending_d     = pending_q;
        best_d        = best_q;
        eval          = (state_q == ST_PLAY) && start && en;
        drain         = (pending_q != 2'd0) && ((state_q == ST_PLAY) || (state_q == ST_OVER));
        n_new         = 2'd0;
        pend_sum      = 3'd0;
        score_pulse_d = 1'b0;

        case (state_q)
            ST_IDLE: if (start) state_d = ST_PLAY;
            ST_PLAY: begin
                if (!start)          state_d = ST_IDLE;
                else if (en && hit)  state_d = ST_OVER;
            end
            ST_OVER: if (!start) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        // A hit on the same tick as a pass suppresses the point
        if (eval && !hit) begin
            passed_d = (passed_q | pass_set) & ~pass_clr;
            n_new    = {1'b0, pass_set[0]} + {1'b0, pass_set[1]} + {1'b0, pass_set[2]};
        end

        pend_sum = {1'b0, pending_q} + {1'b0, n_new} - {2'b00, drain};

        if (state_d == ST_IDLE) begin
            passed_d  = 3'b000;
            pending_d = 2'd0;
        end else begin
            pending_d     = (pend_sum > 3'd3) ? 2'd3 : pend_sum[1:0];
            score_pulse_d = drain;
        end

        // Best only updates once every queued point has reached the score
        if ((state_q == ST_OVER) && (pending_q == 2'd0) && (score_bcd > best_q))
            best_d = score_bcd;
    end

    // State registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            passed_q      <= 3'b000;
            pending_q     <= 2'd0;
            score_pulse_q <= 1'b0;
            best_q        <= 16'h0000;
        end else begin
            state_q       <= state_d;
            passed_q      <= passed_d;
            pending_q     <= pending_d;
            score_pulse_q <= score_pulse_d;
            best_q        <= best_d;
        end
    end

    bcd_counter4 u_score (
        .clk (clk),
        .rst (rst),
        .clr (state_d == ST_IDLE),
        .inc (score_pulse_d),
        .val (score_bcd)
    );

    assign state       = state_q;
    assign game_over   = (state_q == ST_OVER);
    assign score_pulse = score_pulse_q;
    assign best_bcd    = best_q;

endmodule

// File: tb/tb_pipe_judge.sv
module tb_pipe_judge;

    logic        clk = 1'b0;
    logic        rst, en, start;
    logic [11:0] bird_y;
    logic [11:0] px [3];
    logic [11:0] py [3];
    logic [1:0]  state;
    logic        game_over, score_pulse;
    logic [15:0] score_bcd, best_bcd;

    pipe_judge dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .start       (start),
        .bird_y      (bird_y),
        .pipe1_x     (px[0]),
        .pipe2_x     (px[1]),
        .pipe3_x     (px[2]),
        .pipe1_y     (py[0]),
        .pipe2_y     (py[1]),
        .pipe3_y     (py[2]),
        .state       (state),
        .game_over   (game_over),
        .score_pulse (score_pulse),
        .score_bcd   (score_bcd),
        .best_bcd    (best_bcd)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_fail = 0;
    int pulse_cnt = 0;

    // Reference model: 0 idle, 1 play, 2 over; score as plain integers
    int mstate, mscore, mbest, owed;
    bit mp [3];

    function automatic logic [15:0] to_bcd(input int v);
        return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
    endfunction

    function automatic bit model_hit();
        int by, x, y;
        by = int'(bird_y);
        if (by + 24 >= 400) return 1'b1;
        for (int i = 0; i < 3; i++) begin
            x = int'(px[i]);
            y = int'(py[i]);
            if (x < 234 && x + 52 > 200 && (by < y || by + 24 > y + 120)) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step_cycle();
        @(posedge clk);
        #1;
        if (score_pulse === 1'b1) pulse_cnt++;
    endtask

    task automatic model_reset();
        mstate = 0; mscore = 0; mbest = 0; owed = 0; pulse_cnt = 0;
        for (int i = 0; i < 3; i++) mp[i] = 1'b0;
    endtask

    task automatic en_tick();
        int x;
        if (mstate == 1) begin
            if (model_hit()) mstate = 2;
            else begin
                for (int i = 0; i < 3; i++) begin
                    x = int'(px[i]);
                    if (x + 52 < 200 && !mp[i]) begin mp[i] = 1'b1; owed++; end
                    else if (x >= 200) mp[i] = 1'b0;
                end
            end
        end
        en = 1'b1;
        step_cycle();
        en = 1'b0;
    endtask

    task automatic settle();
        repeat (5) step_cycle();
        chk("pulses", pulse_cnt, owed);
        mscore = (mscore + owed > 9999) ? 9999 : mscore + owed;
        owed = 0;
        pulse_cnt = 0;
        if (mstate == 2 && mscore > mbest) mbest = mscore;
        chk("score", score_bcd, to_bcd(mscore));
        chk("state", state, mstate[1:0]);
        chk("game_over", game_over, (mstate == 2));
        chk("best", best_bcd, to_bcd(mbest));
    endtask

    task automatic set_start(input logic v);
        start = v;
        step_cycle();
        if (!v) begin
            mstate = 0; mscore = 0; owed = 0;
            for (int i = 0; i < 3; i++) mp[i] = 1'b0;
        end else if (mstate == 0) begin
            mstate = 1;
        end
    endtask

    task automatic pass_once(input int i);
        px[i] = 12'd640; en_tick();
        px[i] = 12'd100; en_tick();
        settle();
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; start = 1'b0; bird_y = 12'd200;
        for (int i = 0; i < 3; i++) begin px[i] = 12'd600; py[i] = 12'd150; end
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_state", state, 2'b00);
        chk("rst_over", game_over, 1'b0);
        chk("rst_pulse", score_pulse, 1'b0);
        chk("rst_score", score_bcd, 16'h0000);
        chk("rst_best", best_bcd, 16'h0000);
        rst = 1'b0;
        step_cycle();

        // Start and idle flight with pipes far right
        set_start(1'b1);
        repeat (10) en_tick();
        settle();

        // First pass through pipe1 gap, including first-point latency
        px[0] = 12'd160; en_tick();
        px[0] = 12'd150; en_tick();
        px[0] = 12'd140; en_tick();
        chk("lat_pulse_early", score_pulse, 1'b0);
        step_cycle();
        chk("lat_pulse", score_pulse, 1'b1);
        chk("lat_score", score_bcd, 16'h0001);
        px[0] = 12'd130; en_tick();
        px[0] = 12'd120; en_tick();
        settle();
        px[0] = 12'd640; en_tick();
        px[0] = 12'd140; en_tick();
        settle();

        // Digit carry 9 -> 10
        while (mscore < 9) pass_once(0);
        pass_once(0);
        chk("carry_score", score_bcd, 16'h0010);

        // Three pipes passing on one tick
        for (int i = 0; i < 3; i++) px[i] = 12'd640;
        en_tick();
        for (int i = 0; i < 3; i++) px[i] = 12'd100;
        en_tick();
        for (int k = 0; k < 3; k++) begin
            step_cycle();
            chk("triple_pulse", score_pulse, 1'b1);
        end
        settle();
        chk("triple_score", score_bcd, 16'h0013);

        // Gap edge boundaries, then a real hit
        px[0] = 12'd210; py[0] = 12'd200;
        bird_y = 12'd200; en_tick(); settle();
        bird_y = 12'd296; en_tick(); settle();
        bird_y = 12'd199; en_tick();
        chk("hit_state", state, 2'b10);
        chk("hit_over", game_over, 1'b1);
        settle();
        chk("best_after_hit", best_bcd, 16'h0013);

        // Passes in OVER are ignored
        px[1] = 12'd640; en_tick();
        px[1] = 12'd100; en_tick();
        settle();

        // Back to idle, then ground collision
        set_start(1'b0); settle();
        set_start(1'b1);
        for (int i = 0; i < 3; i++) begin px[i] = 12'd600; py[i] = 12'd150; end
        bird_y = 12'd375; en_tick(); settle();
        bird_y = 12'd376; en_tick(); settle();
        chk("ground_over", state, 2'b10);
        bird_y = 12'd200;

        // Reset mid-play with two points still queued
        set_start(1'b0); set_start(1'b1);
        px[0] = 12'd640; px[1] = 12'd640; en_tick();
        px[0] = 12'd100; px[1] = 12'd100; en_tick();
        rst = 1'b1;
        #1;
        chk("mid_rst_state", state, 2'b00);
        chk("mid_rst_over", game_over, 1'b0);
        chk("mid_rst_pulse", score_pulse, 1'b0);
        chk("mid_rst_score", score_bcd, 16'h0000);
        chk("mid_rst_best", best_bcd, 16'h0000);
        start = 1'b0;
        model_reset();
        repeat (2) step_cycle();
        rst = 1'b0;
        pulse_cnt = 0;
        repeat (4) step_cycle();
        chk("post_rst_pulses", pulse_cnt, 0);
        settle();

        // Climb to 9999 with triple passes, then one more pass saturates
        set_start(1'b1);
        for (int i = 0; i < 3; i++) px[i] = 12'd600;
        repeat (3333) begin
            for (int i = 0; i < 3; i++) px[i] = 12'd640;
            en_tick();
            for (int i = 0; i < 3; i++) px[i] = 12'd100;
            en_tick();
            settle();
        end
        chk("sat_reach", score_bcd, 16'h9999);
        pass_once(0);
        chk("sat_hold", score_bcd, 16'h9999);

        // Randomized play against the model
        set_start(1'b0); set_start(1'b1);
        repeat (300) begin
            for (int i = 0; i < 3; i++) begin
                px[i] = 12'($urandom_range(0, 700));
                py[i] = 12'($urandom_range(0, 300));
            end
            bird_y = 12'($urandom_range(100, 390));
            en_tick();
            settle();
            if (mstate == 2) begin
                set_start(1'b0);
                set_start(1'b1);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
